// File: rtl/ucr_wide.sv
// Cascadable up/down counter with parallel load, optional modulus and saturation.
// COUT is combinational so a chain of stages updates as one wide counter in a single cycle.
module ucr_wide #(
    parameter int              WIDTH    = 8,
    parameter longint unsigned MODULO   = 0,
    parameter bit              SATURATE = 1'b0
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [0:WIDTH-1] D,
    input  logic [0:1]       SEL,
    input  logic             CIN,
    input  logic             CLR,
    output logic [0:WIDTH-1] Q,
    output logic             COUT,
    output logic             OVF
);

    localparam logic [1:0] SEL_LOAD = 2'b00;
    localparam logic [1:0] SEL_DEC  = 2'b01;
    localparam logic [1:0] SEL_INC  = 2'b10;
    localparam logic [1:0] SEL_HOLD = 2'b11;

    localparam logic [WIDTH-1:0] MAX  = (MODULO == 0) ? {WIDTH{1'b1}} : WIDTH'(MODULO - 1);
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] d_val;
    logic [1:0]       sel_val;
    logic             at_max, at_zero;

    // Ports are MSB-at-index-0; positional assignment keeps the MSB on the left.
    assign d_val   = D;
    assign sel_val = SEL;
    assign at_max  = (count_q == MAX);
    assign at_zero = (count_q == ZERO);

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (CLR) begin
            count_d = ZERO;
            ovf_d   = 1'b0;
        end else begin
            case (sel_val)
                SEL_LOAD: begin
                    count_d = (d_val > MAX) ? MAX : d_val;
                    ovf_d   = 1'b0;
                end
                SEL_INC: begin
                    if (CIN) begin
                        if (at_max) begin
                            count_d = SATURATE ? MAX : ZERO;
                            ovf_d   = 1'b1;
                        end else begin
                            count_d = count_q + ONE;
                        end
                    end
                end
                SEL_DEC: begin
                    if (CIN) begin
                        if (at_zero) begin
                            count_d = SATURATE ? ZERO : MAX;
                            ovf_d   = 1'b1;
                        end else begin
                            count_d = count_q - ONE;
                        end
                    end
                end
                default: begin
                    count_d = count_q;
                    ovf_d   = ovf_q;
                end
            endcase
        end
    end

    // LOAD drives COUT high so an upper stage sees a defined carry while loading.
    always_comb begin
        COUT = 1'b0;
        case (sel_val)
            SEL_LOAD: COUT = 1'b1;
            SEL_INC:  COUT = CIN & at_max;
            SEL_DEC:  COUT = CIN & at_zero;
            SEL_HOLD: COUT = 1'b0;
            default:  COUT = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            count_q <= ZERO;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign Q   = count_q;
    assign OVF = ovf_q;

endmodule

// File: tb/tb_ucr_wide.sv
// Directed bench for ucr_wide: plain wrap, modulo-10, saturating and a two-stage cascade.
module tb_ucr_wide;

    localparam logic [1:0] LOAD = 2'b00;
    localparam logic [1:0] DEC  = 2'b01;
    localparam logic [1:0] INC  = 2'b10;
    localparam logic [1:0] HOLD = 2'b11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: 8-bit, full range, wrap
    logic [0:7] d_a = '0;
    logic [0:1] sel_a = HOLD;
    logic       cin_a = 1'b0, clr_a = 1'b0;
    logic [0:7] q_a;
    logic       cout_a, ovf_a;
    ucr_wide #(.WIDTH(8), .MODULO(0), .SATURATE(1'b0)) u_a (
        .CLK(clk), .RESET_N(rst_n), .D(d_a), .SEL(sel_a), .CIN(cin_a), .CLR(clr_a),
        .Q(q_a), .COUT(cout_a), .OVF(ovf_a));

    // Instance B: 4-bit, modulo 10, wrap
    logic [0:3] d_b = '0;
    logic [0:1] sel_b = HOLD;
    logic       cin_b = 1'b0, clr_b = 1'b0;
    logic [0:3] q_b;
    logic       cout_b, ovf_b;
    ucr_wide #(.WIDTH(4), .MODULO(10), .SATURATE(1'b0)) u_b (
        .CLK(clk), .RESET_N(rst_n), .D(d_b), .SEL(sel_b), .CIN(cin_b), .CLR(clr_b),
        .Q(q_b), .COUT(cout_b), .OVF(ovf_b));

    // Instance C: 8-bit, saturating
    logic [0:7] d_c = '0;
    logic [0:1] sel_c = HOLD;
    logic       cin_c = 1'b0, clr_c = 1'b0;
    logic [0:7] q_c;
    logic       cout_c, ovf_c;
    ucr_wide #(.WIDTH(8), .MODULO(0), .SATURATE(1'b1)) u_c (
        .CLK(clk), .RESET_N(rst_n), .D(d_c), .SEL(sel_c), .CIN(cin_c), .CLR(clr_c),
        .Q(q_c), .COUT(cout_c), .OVF(ovf_c));

    // Cascade: two 4-bit stages, shared SEL, lower COUT feeds upper CIN
    logic [0:3] d_lo = '0, d_hi = '0;
    logic [0:1] sel_k = HOLD;
    logic       cin_lo = 1'b0, clr_k = 1'b0;
    logic [0:3] q_lo, q_hi;
    logic       cout_lo, cout_hi, ovf_lo, ovf_hi;
    ucr_wide #(.WIDTH(4), .MODULO(0), .SATURATE(1'b0)) u_lo (
        .CLK(clk), .RESET_N(rst_n), .D(d_lo), .SEL(sel_k), .CIN(cin_lo), .CLR(clr_k),
        .Q(q_lo), .COUT(cout_lo), .OVF(ovf_lo));
    ucr_wide #(.WIDTH(4), .MODULO(0), .SATURATE(1'b0)) u_hi (
        .CLK(clk), .RESET_N(rst_n), .D(d_hi), .SEL(sel_k), .CIN(cout_lo), .CLR(clr_k),
        .Q(q_hi), .COUT(cout_hi), .OVF(ovf_hi));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset: state zero, inputs ignored, COUT still decoded with Q=0
        #12;
        chk("rst_q_a", q_a, 8'h00);
        chk("rst_ovf_a", ovf_a, 1'b0);
        sel_a = LOAD; d_a = 8'hAA;
        #1;
        chk("rst_cout_load", cout_a, 1'b1);
        sel_a = DEC; cin_a = 1'b1;
        #1;
        chk("rst_cout_dec0", cout_a, 1'b1);
        sel_a = LOAD;
        step();
        chk("rst_ignore_d", q_a, 8'h00);
        rst_n = 1'b1;

        // A: wrap through 0xFF
        sel_a = LOAD; d_a = 8'hFE; cin_a = 1'b0;
        step();
        chk("a_load_fe", q_a, 8'hFE);
        sel_a = INC; cin_a = 1'b1;
        #1;
        chk("a_cout_fe", cout_a, 1'b0);
        step();
        chk("a_q_ff", q_a, 8'hFF);
        chk("a_cout_ff", cout_a, 1'b1);
        chk("a_ovf_ff", ovf_a, 1'b0);
        step();
        chk("a_q_00", q_a, 8'h00);
        chk("a_cout_00", cout_a, 1'b0);
        chk("a_ovf_00", ovf_a, 1'b1);
        step();
        chk("a_q_01", q_a, 8'h01);
        chk("a_ovf_01", ovf_a, 1'b1);
        cin_a = 1'b0;
        step();
        chk("a_inc_cin0", q_a, 8'h01);
        sel_a = HOLD; cin_a = 1'b1;
        #1;
        chk("a_cout_hold", cout_a, 1'b0);
        step();
        chk("a_hold", q_a, 8'h01);
        sel_a = DEC;
        step();
        chk("a_dec_00", q_a, 8'h00);
        chk("a_cout_dec0", cout_a, 1'b1);
        step();
        chk("a_dec_wrap", q_a, 8'hFF);
        chk("a_ovf_sticky", ovf_a, 1'b1);
        // CLR overrides DEC and clears OVF
        clr_a = 1'b1;
        step();
        chk("a_clr_dec_q", q_a, 8'h00);
        chk("a_clr_dec_ovf", ovf_a, 1'b0);
        clr_a = 1'b0; sel_a = LOAD; d_a = 8'h55;
        step();
        chk("a_load_55", q_a, 8'h55);
        clr_a = 1'b1; sel_a = INC; cin_a = 1'b1;
        step();
        chk("a_clr_inc_q", q_a, 8'h00);
        chk("a_clr_inc_ovf", ovf_a, 1'b0);
        clr_a = 1'b0; sel_a = LOAD; d_a = 8'h37;
        step();
        sel_a = HOLD;
        for (int i = 0; i < 4; i++) begin
            cin_a = ~cin_a;
            step();
        end
        chk("a_hold_toggle", q_a, 8'h37);

        // B: modulo 10
        sel_b = LOAD; d_b = 4'hF;
        step();
        chk("b_load_clamp", q_b, 4'h9);
        d_b = 4'h5;
        step();
        chk("b_load_5", q_b, 4'h5);
        d_b = 4'h0;
        step();
        sel_b = DEC; cin_b = 1'b1;
        #1;
        chk("b_cout_dec0", cout_b, 1'b1);
        step();
        chk("b_dec_wrap", q_b, 4'h9);
        chk("b_dec_ovf", ovf_b, 1'b1);
        sel_b = INC;
        #1;
        chk("b_cout_inc9", cout_b, 1'b1);
        step();
        chk("b_inc_wrap", q_b, 4'h0);
        chk("b_inc_ovf", ovf_b, 1'b1);

        // C: saturating
        sel_c = LOAD; d_c = 8'hFF;
        step();
        sel_c = INC; cin_c = 1'b1;
        step();
        chk("c_sat_hi1", q_c, 8'hFF);
        chk("c_sat_ovf1", ovf_c, 1'b1);
        step();
        chk("c_sat_hi2", q_c, 8'hFF);
        sel_c = LOAD; d_c = 8'h00;
        step();
        chk("c_load_ovf", ovf_c, 1'b0);
        sel_c = DEC;
        step();
        chk("c_sat_lo", q_c, 8'h00);
        chk("c_sat_lo_ovf", ovf_c, 1'b1);

        // Cascade
        sel_k = LOAD; d_hi = 4'h0; d_lo = 4'hF;
        step();
        chk("k_load_0f", {q_hi, q_lo}, 8'h0F);
        sel_k = INC; cin_lo = 1'b1;
        step();
        chk("k_inc_10", {q_hi, q_lo}, 8'h10);
        chk("k_ovf_hi0", ovf_hi, 1'b0);
        sel_k = LOAD; d_hi = 4'hF; d_lo = 4'hF;
        step();
        sel_k = INC;
        step();
        chk("k_inc_00", {q_hi, q_lo}, 8'h00);
        chk("k_ovf_hi1", ovf_hi, 1'b1);

        // Async reset pulse between edges mid-count
        sel_a = LOAD; d_a = 8'hFF;
        step();
        sel_a = INC; cin_a = 1'b1;
        step();
        step();
        chk("r_pre_q", q_a, 8'h01);
        #2 rst_n = 1'b0;
        #1;
        chk("r_async_q", q_a, 8'h00);
        chk("r_async_ovf", ovf_a, 1'b0);
        #2 rst_n = 1'b1;
        step();
        chk("r_restart1", q_a, 8'h01);
        step();
        chk("r_restart2", q_a, 8'h02);
        chk("r_restart_ovf", ovf_a, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
